// File: rtl/vending_machine_pkg.sv
// Shared vending-machine constants, money types and the coin-return FSM state encoding.
package vending_machine_pkg;

  localparam int unsigned NUM_COINS  = 3;
  localparam int unsigned TOTAL_BITS = 31;
  localparam int unsigned COIN_VAL0  = 100;
  localparam int unsigned COIN_VAL1  = 500;
  localparam int unsigned COIN_VAL2  = 1000;

  typedef logic [TOTAL_BITS-1:0] money_t;
  typedef logic [NUM_COINS-1:0]  coin_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DISPENSE,
    DONE
  } state_e;

  function automatic money_t coin_value(input int unsigned idx);
    case (idx)
      0:       return money_t'(COIN_VAL0);
      1:       return money_t'(COIN_VAL1);
      2:       return money_t'(COIN_VAL2);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_return_dispenser_if.sv
// Request and hopper handshake bundle of the coin-return dispenser.
interface coin_return_dispenser_if;
  import vending_machine_pkg::*;

  logic       i_return_req;
  money_t     i_balance;
  coin_mask_t i_hopper_empty;
  logic       i_hopper_ack;
  logic       o_hopper_valid;
  coin_mask_t o_hopper_coin;
  logic       o_busy;
  logic       o_done;
  money_t     o_residual;
  money_t     o_return_total;

  // Requester / hopper side.
  modport master (
    output i_return_req, i_balance, i_hopper_empty, i_hopper_ack,
    input  o_hopper_valid, o_hopper_coin, o_busy, o_done, o_residual, o_return_total
  );

  // Dispenser side.
  modport slave (
    input  i_return_req, i_balance, i_hopper_empty, i_hopper_ack,
    output o_hopper_valid, o_hopper_coin, o_busy, o_done, o_residual, o_return_total
  );
endinterface

// File: rtl/coin_return_dispenser_coin_select.sv
// Greedy coin picker: largest in-stock denomination not exceeding the remaining amount.
module coin_select
  import vending_machine_pkg::*;
(
  input  money_t     remaining,
  input  coin_mask_t empty,
  output logic       found,
  output coin_mask_t coin,
  output money_t     value
);

  always_comb begin
    found = 1'b0;
    coin  = '0;
    value = '0;
    for (int i = int'(NUM_COINS) - 1; i >= 0; i--) begin
      if (!found && !empty[i] && (coin_value(unsigned'(i)) <= remaining)) begin
        found = 1'b1;
        coin  = coin_mask_t'(1) << i;
        value = coin_value(unsigned'(i));
      end
    end
  end

endmodule

// File: rtl/coin_return_dispenser.sv
// Converts a return balance into single coins on the hopper handshake and keeps the
// running total of money returned since reset.
module coin_return_dispenser
  import vending_machine_pkg::*;
(
  input logic                    clk,
  input logic                    reset_n,
  coin_return_dispenser_if.slave bus
);

  state_e     state_q, state_d;
  money_t     remaining_q, remaining_d;
  money_t     value_q, value_d;
  money_t     residual_q, residual_d;
  money_t     total_q, total_d;
  logic       valid_q, valid_d;
  coin_mask_t coin_q, coin_d;

  logic       sel_found;
  coin_mask_t sel_coin;
  money_t     sel_value;

  coin_select u_coin_select (
    .remaining (remaining_q),
    .empty     (bus.i_hopper_empty),
    .found     (sel_found),
    .coin      (sel_coin),
    .value     (sel_value)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    value_d     = value_q;
    residual_d  = residual_q;
    total_d     = total_q;
    valid_d     = valid_q;
    coin_d      = coin_q;
    case (state_q)
      IDLE: begin
        if (bus.i_return_req) begin
          remaining_d = bus.i_balance;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          valid_d = 1'b1;
          coin_d  = sel_coin;
          // Latch the value so stock changes mid-handshake cannot alter the accounting.
          value_d = sel_value;
          state_d = DISPENSE;
        end else begin
          residual_d = remaining_q;
          state_d    = DONE;
        end
      end
      DISPENSE: begin
        if (bus.i_hopper_ack) begin
          valid_d     = 1'b0;
          remaining_d = remaining_q - value_q;
          total_d     = total_q + value_q;
          state_d     = SELECT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      value_q     <= '0;
      residual_q  <= '0;
      total_q     <= '0;
      valid_q     <= 1'b0;
      coin_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      value_q     <= value_d;
      residual_q  <= residual_d;
      total_q     <= total_d;
      valid_q     <= valid_d;
      coin_q      <= coin_d;
    end
  end

  assign bus.o_hopper_valid = valid_q;
  assign bus.o_hopper_coin  = coin_q;
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_done         = (state_q == DONE);
  assign bus.o_residual     = residual_q;
  assign bus.o_return_total = total_q;

endmodule

// File: doc/coin_return_dispenser.md
Name: coin_return_dispenser

Overview:
- Downstream end of the coin-return path in the vending machine.
- Accepts a return request carrying the customer's remaining balance and converts it to individual coins using a greedy, largest-first selection.
- Drives the coin hopper one coin at a time over a valid/ack handshake.
- Maintains the cumulative returned-money total that feeds back into the balance arithmetic.

Parameters:
- NUM_COINS, 3, number of coin denominations (index 0 = smallest).
- TOTAL_BITS, 31, width of all money quantities.
- COIN_VAL0, 100, value of coin index 0.
- COIN_VAL1, 500, value of coin index 1.
- COIN_VAL2, 1000, value of coin index 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- i_return_req  input  1  start a return; sampled only in IDLE.
- i_balance  input  TOTAL_BITS  amount to return; latched with i_return_req.
- i_hopper_empty  input  NUM_COINS  bit i = 1: denomination i out of stock.
- i_hopper_ack  input  1  hopper has ejected the presented coin.
- o_hopper_valid  output  1  coin request presented to the hopper.
- o_hopper_coin  output  NUM_COINS  one-hot denomination; meaningful only while valid.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse at the end of a return.
- o_residual  output  TOTAL_BITS  amount that could not be returned; held until the next request.
- o_return_total  output  TOTAL_BITS  cumulative value of all coins dispensed since reset.

Behaviour:
- Reset (reset_n=0 sampled at an edge):
  - state=IDLE.
  - o_hopper_valid=0, o_hopper_coin=0, o_busy=0, o_done=0.
  - o_residual=0, o_return_total=0, remaining=0.
  - Reset mid-operation aborts immediately; a coin presented but not yet acked is not counted.
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - i_return_req=1 at an edge: remaining <= i_balance, go to SELECT.
  - Otherwise stay in IDLE.
- SELECT (exactly one cycle):
  - Pick the highest index i with COIN_VALi <= remaining and i_hopper_empty[i]=0.
  - Coin found: o_hopper_coin <= onehot(i), o_hopper_valid <= 1, go to DISPENSE.
  - No coin found: o_residual <= remaining, go to DONE.
- DISPENSE:
  - Hold o_hopper_valid and o_hopper_coin stable until i_hopper_ack=1 is sampled.
  - Changes on i_hopper_empty during DISPENSE are ignored.
  - On ack: o_hopper_valid <= 0, remaining <= remaining - value, o_return_total <= o_return_total + value, go to SELECT.
  - i_hopper_ack outside DISPENSE is ignored.
- DONE:
  - o_done=1 for this single cycle, then go to IDLE.
- Latency:
  - Request sampled at edge N: o_hopper_valid rises after edge N+1.
  - With zero-wait ack, each coin costs 2 cycles (DISPENSE + SELECT).
  - i_balance=0: o_done is high in the cycle after edge N+1, and no valid is issued.
- i_return_req while o_busy=1: ignored, not queued.
- Arithmetic:
  - remaining never underflows, because selection guarantees value <= remaining.
  - o_return_total wraps modulo 2^TOTAL_BITS; no saturation.
- o_busy is a combinational decode of state != IDLE.

Decomposition:
- Shared package vending_machine_pkg holds:
  - NUM_COINS, TOTAL_BITS, the coin value constants.
  - The state enum {IDLE, SELECT, DISPENSE, DONE}.
- The same constants are reused by the existing timer/coin-return logic.
- One combinational sub-module, coin_select:
  - Inputs: remaining, empty mask.
  - Outputs: found flag, one-hot coin, coin value.
  - Greedy search from the highest index down.

Test Plan:
- i_balance=1600, nothing empty, ack 1 cycle after valid -> coins 1000, 500, 100 in order; o_residual=0; o_return_total=1600; one o_done pulse.
- i_balance=250 -> coins 100, 100; o_residual=50; o_return_total +=200.
- i_hopper_empty=3'b100, i_balance=1500 -> coins 500, 500, 500; o_residual=0.
- Ack delayed 4 cycles, i_hopper_empty toggled during wait -> o_hopper_valid and o_hopper_coin stable throughout; one coin counted.
- i_balance=0 -> no valid; o_done after edge N+1; second i_return_req pulsed while busy on a 1000 return -> ignored, only one o_done.
- reset_n=0 during DISPENSE of the 2nd coin of 1500 -> next cycle all outputs 0, o_return_total=0, state IDLE; a new request of 500 completes normally.
